// File: rtl/uart_rx_param.sv
// Oversampling asynchronous serial receiver with programmable baud divider,
// optional parity, 1 or 2 stop bits, false-start rejection and break handling.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic [DIV_WIDTH-1:0] iDiv,
    input  logic                 iRx,
    output logic [DATA_BITS-1:0] oData,
    output logic                 oValid,
    output logic                 oParityErr,
    output logic                 oFrameErr,
    output logic                 oBusy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] SCNT_LAST      = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SCNT_MID       = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BCNT_DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BCNT_STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    logic                 rx_meta_q, rx_s_q;
    logic [1:0]           settle_q;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_lim_q;
    logic                 tick;

    state_t               state_q, state_d;
    logic [SW-1:0]        scnt_q, scnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 armed_q, armed_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_o_q, perr_o_d;
    logic                 ferr_o_q, ferr_o_d;
    logic                 stop_ferr;

    // settle_q marks when rx_s reflects the real line rather than the reset value,
    // so a line that is already low after reset can never arm the receiver.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            settle_q  <= 2'b00;
        end else begin
            rx_meta_q <= iRx;
            rx_s_q    <= rx_meta_q;
            settle_q  <= {settle_q[0], 1'b1};
        end
    end

    // The limit is reloaded only on wrap, so a new divider never truncates a tick period.
    assign tick = (div_cnt_q == div_lim_q);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            div_cnt_q <= '0;
            div_lim_q <= '0;
        end else if (tick) begin
            div_cnt_q <= '0;
            div_lim_q <= (iDiv == '0) ? '0 : iDiv - DIV_WIDTH'(1);
        end else begin
            div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q  <= S_IDLE;
            scnt_q   <= '0;
            bcnt_q   <= '0;
            shift_q  <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            armed_q  <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            perr_o_q <= 1'b0;
            ferr_o_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            scnt_q   <= scnt_d;
            bcnt_q   <= bcnt_d;
            shift_q  <= shift_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            armed_q  <= armed_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            perr_o_q <= perr_o_d;
            ferr_o_q <= ferr_o_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        armed_d   = armed_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_o_d  = perr_o_q;
        ferr_o_d  = ferr_o_q;
        stop_ferr = ferr_q | ~rx_s_q;

        case (state_q)
            S_IDLE: begin
                if (rx_s_q && settle_q[1]) begin
                    armed_d = 1'b1;
                end
                if (tick && !rx_s_q && armed_q) begin
                    state_d = S_START;
                    scnt_d  = '0;
                    armed_d = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end

            S_START: begin
                if (tick) begin
                    if (scnt_q == SCNT_MID) begin
                        if (rx_s_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                            scnt_d  = '0;
                            bcnt_d  = '0;
                        end
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
            end

            S_DATA: begin
                if (tick) begin
                    if (scnt_q == SCNT_LAST) begin
                        scnt_d  = '0;
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bcnt_d  = bcnt_q + BW'(1);
                        if (bcnt_q == BCNT_DATA_LAST) begin
                            bcnt_d  = '0;
                            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
            end

            S_PARITY: begin
                if (tick) begin
                    if (scnt_q == SCNT_LAST) begin
                        scnt_d  = '0;
                        bcnt_d  = '0;
                        perr_d  = (^shift_q) ^ rx_s_q ^ 1'(PARITY_ODD);
                        state_d = S_STOP;
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
            end

            S_STOP: begin
                if (tick) begin
                    if (scnt_q == SCNT_LAST) begin
                        scnt_d = '0;
                        ferr_d = stop_ferr;
                        if (bcnt_q == BCNT_STOP_LAST) begin
                            bcnt_d   = '0;
                            data_d   = shift_q;
                            valid_d  = 1'b1;
                            perr_o_d = (PARITY_EN != 0) ? perr_q : 1'b0;
                            ferr_o_d = stop_ferr;
                            state_d  = rx_s_q ? S_IDLE : S_BREAK;
                        end else begin
                            bcnt_d = bcnt_q + BW'(1);
                        end
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
            end

            S_BREAK: begin
                if (tick && rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign oData      = data_q;
    assign oValid     = valid_q;
    assign oParityErr = perr_o_q;
    assign oFrameErr  = ferr_o_q;
    assign oBusy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default 8E1 instance at iDiv=1 and a
// 7O2 instance at iDiv=3, each with an expected-word queue.
module tb_uart_rx_param;

    localparam int BIT_A = 16;
    localparam int BIT_B = 48;

    logic        clk;
    logic        rst_n;
    logic [15:0] div_a, div_b;
    logic        rx_a, rx_b;
    logic [7:0]  data_a;
    logic [6:0]  data_b;
    logic        valid_a, perr_a, ferr_a, busy_a;
    logic        valid_b, perr_b, ferr_b, busy_b;

    int n_chk = 0;
    int n_bad = 0;

    // expected words packed as {parity_err, frame_err, data}
    logic [9:0] exp_a_q[$];
    logic [8:0] exp_b_q[$];

    uart_rx_param u_dut_a (
        .iClk(clk), .iRst_n(rst_n), .iDiv(div_a), .iRx(rx_a),
        .oData(data_a), .oValid(valid_a), .oParityErr(perr_a),
        .oFrameErr(ferr_a), .oBusy(busy_a)
    );

    uart_rx_param #(
        .DATA_BITS(7), .PARITY_ODD(1), .STOP_BITS(2)
    ) u_dut_b (
        .iClk(clk), .iRst_n(rst_n), .iDiv(div_b), .iRx(rx_b),
        .oData(data_b), .oValid(valid_b), .oParityErr(perr_b),
        .oFrameErr(ferr_b), .oBusy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_a(input logic b, input int n_clk);
        rx_a = b;
        repeat (n_clk) @(negedge clk);
    endtask

    task automatic bit_b(input logic b, input int n_clk);
        rx_b = b;
        repeat (n_clk) @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] d, input logic p, input logic s);
        bit_a(1'b0, BIT_A);
        for (int i = 0; i < 8; i++) bit_a(d[i], BIT_A);
        bit_a(p, BIT_A);
        bit_a(s, BIT_A);
        bit_a(1'b1, BIT_A);
    endtask

    task automatic send_b(input logic [6:0] d, input logic p, input logic s1, input logic s2);
        bit_b(1'b0, BIT_B);
        for (int i = 0; i < 7; i++) bit_b(d[i], BIT_B);
        bit_b(p, BIT_B);
        bit_b(s1, BIT_B);
        bit_b(s2, BIT_B);
        bit_b(1'b1, BIT_B);
    endtask

    // scoreboard: every valid pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && valid_a) begin
            if (exp_a_q.size() == 0) chk("a_unexpected_valid", valid_a, 0);
            else chk("a_word", {perr_a, ferr_a, data_a}, exp_a_q.pop_front());
        end
        if (rst_n && valid_b) begin
            if (exp_b_q.size() == 0) chk("b_unexpected_valid", valid_b, 0);
            else chk("b_word", {perr_b, ferr_b, data_b}, exp_b_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        div_a = 16'd1;
        div_b = 16'd3;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data_a", data_a, 0);
        chk("rst_valid_a", valid_a, 0);
        chk("rst_perr_a", perr_a, 0);
        chk("rst_ferr_a", ferr_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_busy_b", busy_b, 0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // clean 8E1 frame
        exp_a_q.push_back({1'b0, 1'b0, 8'hA5});
        send_a(8'hA5, 1'b0, 1'b1);
        chk("a5_drain", exp_a_q.size(), 0);
        chk("a5_busy_end", busy_a, 0);
        repeat (40) @(negedge clk);
        chk("a5_hold", data_a, 8'hA5);

        // wrong parity bit: word still delivered, parity flagged
        exp_a_q.push_back({1'b1, 1'b0, 8'hA5});
        send_a(8'hA5, 1'b1, 1'b1);
        chk("par_drain", exp_a_q.size(), 0);
        chk("par_flag_held", perr_a, 1);

        // stop bit low followed by a long break: exactly one framing-error word
        exp_a_q.push_back({1'b0, 1'b1, 8'h3C});
        bit_a(1'b0, BIT_A);
        for (int i = 0; i < 8; i++) bit_a(n_chk[31] ^ ((8'h3C >> i) & 1'b1), BIT_A);
        bit_a(1'b0, BIT_A);
        bit_a(1'b0, 20 * BIT_A);
        chk("brk_busy", busy_a, 1);
        chk("brk_drain", exp_a_q.size(), 0);
        bit_a(1'b0, 20 * BIT_A);
        bit_a(1'b1, 3 * BIT_A);
        chk("brk_idle", busy_a, 0);
        chk("brk_ferr_held", ferr_a, 1);
        exp_a_q.push_back({1'b0, 1'b0, 8'h5A});
        send_a(8'h5A, 1'b0, 1'b1);
        chk("after_brk_drain", exp_a_q.size(), 0);

        // 5-clock low glitch: false start rejected
        repeat (40) @(negedge clk);
        rx_a = 1'b0;
        repeat (5) @(negedge clk);
        chk("glitch_busy", busy_a, 1);
        rx_a = 1'b1;
        n = 0;
        while (busy_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("glitch_idle", busy_a, 0);
        chk("glitch_within_8", (n <= 8), 1);
        repeat (3 * BIT_A) @(negedge clk);
        chk("glitch_data_kept", data_a, 8'h5A);

        // 7O2 instance at iDiv=3
        exp_b_q.push_back({1'b0, 1'b0, 7'h55});
        send_b(7'h55, 1'b1, 1'b1, 1'b1);
        chk("b_ok_drain", exp_b_q.size(), 0);
        chk("b_ok_busy", busy_b, 0);
        repeat (BIT_B) @(negedge clk);
        exp_b_q.push_back({1'b0, 1'b1, 7'h55});
        send_b(7'h55, 1'b1, 1'b1, 1'b0);
        repeat (BIT_B) @(negedge clk);
        chk("b_ferr_drain", exp_b_q.size(), 0);
        chk("b_ferr_busy", busy_b, 0);

        // reset in the middle of data bit 4 of an 0xE5 frame
        bit_a(1'b0, BIT_A);
        for (int i = 0; i < 4; i++) bit_a(((8'hE5 >> i) & 1'b1), BIT_A);
        bit_a(1'b0, BIT_A / 2);
        chk("rst_mid_busy_pre", busy_a, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_data_a", data_a, 0);
        chk("rst_mid_busy_a", busy_a, 0);
        chk("rst_mid_ferr_b", ferr_b, 0);
        chk("rst_mid_data_b", data_b, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bit_a(1'b0, BIT_A / 2);
        chk("rst_low_ignored", busy_a, 0);
        bit_a(1'b1, 3 * BIT_A);
        chk("rst_idle", busy_a, 0);
        chk("rst_valid_low", valid_a, 0);
        exp_a_q.push_back({1'b0, 1'b0, 8'h81});
        send_a(8'h81, 1'b0, 1'b1);
        chk("r81_drain", exp_a_q.size(), 0);
        chk("r81_busy", busy_a, 0);

        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised asynchronous serial receiver: start bit, DATA_BITS data bits LSB first, optional even/odd parity bit, 1 or 2 stop bits.
- Oversamples the line at OVERSAMPLE ticks per bit using a runtime-programmable clock divider.
- Rejects false starts, and flags parity and framing errors alongside each received word.
- Sits between the board RX pin and the character/display logic of the practice design; replaces the fixed 8-bit receiver.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- OVERSAMPLE, 16, ticks per bit period (even, 4..32).
- DIV_WIDTH, 16, width of iDiv.
- PARITY_EN, 1, 1 = parity bit present after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- iClk  in  1  system clock; all logic on its rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- iDiv  in  DIV_WIDTH  iClk cycles per oversample tick; value 0 is treated as 1.
- iRx  in  1  serial line, idle high, asynchronous to iClk.
- oData  out  DATA_BITS  last received word, held until the next oValid.
- oValid  out  1  one-cycle pulse when a frame completes.
- oParityErr  out  1  parity mismatch on the frame flagged by oValid; held with oData.
- oFrameErr  out  1  a stop bit sampled low on that frame; held with oData.
- oBusy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): every output is 0, FSM is IDLE, divider and counters are 0, synchroniser flops are 1.
- Synchroniser: iRx passes through 2 flops; only the synchronised value (rx_s) is used anywhere.
- Tick generator: free-running counter 0..max(iDiv,1)-1; tick is 1 for one iClk in the cycle the counter equals the maximum. A change to iDiv takes effect on the next wrap.
- Sample counter scnt is 0..OVERSAMPLE-1 and advances only on a tick.
- IDLE: on a tick with rx_s=0, clear scnt and go to START.
- START: on the tick where scnt = OVERSAMPLE/2-1 (mid-bit):
  - rx_s=1: false start; return to IDLE with no output.
  - rx_s=0: clear scnt, clear the bit counter, go to DATA.
- DATA: every OVERSAMPLE ticks (scnt = OVERSAMPLE-1, i.e. mid-bit), shift rx_s into the MSB of the shift register (LSB-first frame) and increment the bit counter. After DATA_BITS samples go to PARITY if PARITY_EN, else STOP.
- PARITY: one sample. perr = (XOR of data bits XOR sampled bit) XOR PARITY_ODD; perr=1 means an error. Then go to STOP.
- STOP: STOP_BITS samples. Any low sample sets ferr.
- Completion: on the iClk after the final stop-bit sample:
  - oData takes the shift register.
  - oParityErr takes perr (0 if PARITY_EN=0).
  - oFrameErr takes ferr.
  - oValid=1 for exactly that cycle.
  - Next state: IDLE if the last stop sample was 1, else BREAK.
- oData is updated even when an error flag is set.
- BREAK: wait for a tick with rx_s=1, then go to IDLE. A held-low line produces exactly one frame-error word, not repeated frames.
- Latency: oValid rises 1 iClk after the tick of the final mid-stop-bit sample. Overall frame-to-oValid ≈ (1+DATA_BITS+PARITY_EN+STOP_BITS-0.5) bit periods plus 2 synchroniser cycles plus 1 cycle.
- The bit counter and scnt wrap only under FSM control; they never overflow.
- iRst_n asserted mid-frame aborts immediately: no oValid, outputs cleared. After release the receiver needs a falling edge; a line already low is ignored until it has been seen high (the synchroniser resets to 1, so IDLE requires an observed 1→0). Implement this with an arm flag set by rx_s=1 in IDLE.

Test Plan:
- Defaults, iDiv=1 (16 clk/bit); send 0xA5 with parity 0 and stop 1 -> one oValid pulse, oData=0xA5, oParityErr=0, oFrameErr=0, oBusy returns to 0.
- Same frame with the parity bit flipped to 1 -> oData=0xA5, oParityErr=1, oFrameErr=0.
- Send 0x3C with the stop bit driven 0, then hold the line low for 40 bit periods, then release high -> exactly one oValid with oFrameErr=1; no further oValid until the next valid start bit.
- Low glitch of 5 clk on an idle line (iDiv=1) -> no oValid, oBusy returns to 0 within 8 ticks.
- PARITY_ODD=1, STOP_BITS=2, DATA_BITS=7, iDiv=3; send 0x55 with odd parity bit 1 -> oData=0x55, no errors; second stop bit driven 0 -> oFrameErr=1.
- iRst_n pulsed low mid data bit 4 of a frame -> outputs 0 immediately, no oValid for that frame; next full frame 0x81 is received correctly.
